// File: rtl/ember_alu.sv
// Shared integer ALU of the Ember core: single-cycle arithmetic/logic/shift/multiply
// plus an iterative restoring divider for unsigned divide and remainder.
module ember_alu #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        op,
  input  logic              valid,
  output logic [DATA_W-1:0] res,
  output logic              done,
  output logic              zero,
  output logic              carry,
  output logic              overflow,
  output logic              lt,
  output logic              eq,
  output logic              gt
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_NOT  = 8'h05;
  localparam logic [7:0] OP_SHL  = 8'h06;
  localparam logic [7:0] OP_SHR  = 8'h07;
  localparam logic [7:0] OP_SAR  = 8'h08;
  localparam logic [7:0] OP_CMP  = 8'h09;
  localparam logic [7:0] OP_MUL  = 8'h0A;
  localparam logic [7:0] OP_DIVU = 8'h0B;
  localparam logic [7:0] OP_REMU = 8'h0C;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_INC  = 8'h0E;
  localparam logic [7:0] OP_DEC  = 8'h0F;

  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                done_q, done_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                lt_q, lt_d;
  logic                eq_q, eq_d;
  logic                gt_q, gt_d;

  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                is_rem_q, is_rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          cmp_sv_q, cmp_sv_d;

  logic [DATA_W:0]     add_w, sub_w, inc_w, dec_w;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v, alu_def;
  logic                s_lt, s_eq, s_gt;
  logic                msb_a, msb_b;

  logic [DATA_W:0]     rem_sh, trial;
  logic [DATA_W-1:0]   rem_step, quo_step;
  logic [DATA_W-1:0]   div_res;

  // Single-cycle datapath
  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    inc_w   = {1'b0, a} + (DATA_W+1)'(1);
    dec_w   = {1'b0, a} - (DATA_W+1)'(1);
    shamt   = b[SH_W-1:0];
    msb_a   = a[DATA_W-1];
    msb_b   = b[DATA_W-1];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_def = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res = add_w[DATA_W-1:0];
        alu_c   = add_w[DATA_W];
        alu_v   = (msb_a == msb_b) && (add_w[DATA_W-1] != msb_a);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_w[DATA_W-1:0];
        alu_c   = sub_w[DATA_W];
        alu_v   = (msb_a != msb_b) && (sub_w[DATA_W-1] != msb_a);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_SHL:  alu_res = a << shamt;
      OP_SHR:  alu_res = a >> shamt;
      OP_SAR:  alu_res = $signed(a) >>> shamt;
      OP_MUL:  alu_res = a * b;
      OP_MOV:  alu_res = b;
      OP_INC: begin
        alu_res = inc_w[DATA_W-1:0];
        alu_c   = inc_w[DATA_W];
        alu_v   = (a == SMAX);
      end
      OP_DEC: begin
        alu_res = dec_w[DATA_W-1:0];
        alu_c   = dec_w[DATA_W];
        alu_v   = (a == SMIN);
      end
      OP_DIVU, OP_REMU: alu_res = '0;
      default: alu_def = 1'b0;
    endcase
    s_lt = $signed(a) < $signed(b);
    s_eq = (a == b);
    s_gt = !s_lt && !s_eq;
  end

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    trial  = rem_sh - {1'b0, dvsr_q};
    if (!trial[DATA_W]) begin
      rem_step = trial[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], 1'b0};
    end
    div_res = is_rem_q ? rem_q : quo_q;
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    is_rem_d = is_rem_q;
    cnt_d    = cnt_q;
    cmp_sv_d = cmp_sv_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (op == OP_DIVU || op == OP_REMU) begin
            quo_d    = a;
            rem_d    = '0;
            dvsr_d   = b;
            is_rem_d = (op == OP_REMU);
            cnt_d    = CNT_W'(DATA_W);
            cmp_sv_d = {s_lt, s_eq, s_gt};
            state_d  = S_DIV;
          end else begin
            res_d   = alu_res;
            done_d  = 1'b1;
            zero_d  = alu_def && (alu_res == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
            lt_d    = alu_def && s_lt;
            eq_d    = alu_def && s_eq;
            gt_d    = alu_def && s_gt;
          end
        end
      end
      S_DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        // A zero divisor naturally yields all-ones quotient and remainder == dividend
        res_d   = div_res;
        done_d  = 1'b1;
        zero_d  = (div_res == '0);
        carry_d = 1'b0;
        ovf_d   = (dvsr_q == '0);
        lt_d    = cmp_sv_q[2];
        eq_d    = cmp_sv_q[1];
        gt_d    = cmp_sv_q[0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
      cnt_q    <= '0;
      cmp_sv_q <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      is_rem_q <= is_rem_d;
      cnt_q    <= cnt_d;
      cmp_sv_q <= cmp_sv_d;
    end
  end

  assign res      = res_q;
  assign done     = done_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign lt       = lt_q;
  assign eq       = eq_q;
  assign gt       = gt_q;

endmodule

// File: tb/tb_ember_alu.sv
// Bench for ember_alu: arithmetic reference model with a per-cycle checker plus
// hand-computed expectations for the key corner cases.
module tb_ember_alu;

  logic        clk;
  logic        rst;
  logic [63:0] a, b;
  logic [7:0]  op;
  logic        valid;
  logic [63:0] res;
  logic        done, zero, carry, overflow, lt, eq, gt;

  ember_alu #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .valid(valid),
    .res(res), .done(done), .zero(zero), .carry(carry),
    .overflow(overflow), .lt(lt), .eq(eq), .gt(gt)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        lt;
    logic        eq;
    logic        gt;
  } exp_t;

  typedef struct {
    int   due;
    exp_t e;
  } pend_t;

  pend_t pq[$];
  exp_t  last;
  exp_t  act;
  int    cyc = 0;
  int    free_from = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] actv, input logic [127:0] expv);
    n_chk++;
    if (actv !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, actv, expv);
    end
  endtask

  function automatic bit fits64(input logic signed [127:0] w);
    return (w <= 128'sh7FFF_FFFF_FFFF_FFFF) && (w >= -128'sh8000_0000_0000_0000);
  endfunction

  // Reference model from the opcode definitions, plain arithmetic
  function automatic exp_t model(input logic [7:0] o, input logic [63:0] x, input logic [63:0] y);
    exp_t r;
    logic signed [127:0] w;
    logic [5:0] sh;
    bit def;
    r = '0;
    def = 1;
    sh = y[5:0];
    case (o)
      8'h00: begin r.res = x + y; r.carry = ({64'd0, x} + {64'd0, y}) > 128'hFFFF_FFFF_FFFF_FFFF;
                   w = $signed(x) + $signed(y); r.ovf = !fits64(w); end
      8'h01, 8'h09: begin r.res = x - y; r.carry = (x < y);
                   w = $signed(x) - $signed(y); r.ovf = !fits64(w); end
      8'h02: r.res = x & y;
      8'h03: r.res = x | y;
      8'h04: r.res = x ^ y;
      8'h05: r.res = ~x;
      8'h06: r.res = x << sh;
      8'h07: r.res = x >> sh;
      8'h08: r.res = $signed(x) >>> sh;
      8'h0A: r.res = x * y;
      8'h0B: begin r.res = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y; r.ovf = (y == 0); end
      8'h0C: begin r.res = (y == 0) ? x : x % y; r.ovf = (y == 0); end
      8'h0D: r.res = y;
      8'h0E: begin r.res = x + 1; r.carry = (x == 64'hFFFF_FFFF_FFFF_FFFF);
                   w = $signed(x) + 128'sd1; r.ovf = !fits64(w); end
      8'h0F: begin r.res = x - 1; r.carry = (x == 0);
                   w = $signed(x) - 128'sd1; r.ovf = !fits64(w); end
      default: def = 0;
    endcase
    if (def) begin
      r.zero = (r.res == 0);
      r.lt   = $signed(x) < $signed(y);
      r.eq   = (x == y);
      r.gt   = $signed(x) > $signed(y);
    end
    return r;
  endfunction

  // Per-cycle checker: done exactly when a completion is due, outputs always equal the last completion
  always @(negedge clk) begin
    if (chk_en) begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        last = pq[0].e;
        void'(pq.pop_front());
        chk("done_pulse", 128'(done), 128'(1));
      end else begin
        chk("done_idle", 128'(done), 128'(0));
      end
      act = {res, zero, carry, overflow, lt, eq, gt};
      chk("outputs", 128'(act), 128'(last));
    end
  end

  // Drive one request for one cycle; starts and ends just after a falling edge
  task automatic drive(input logic [7:0] o, input logic [63:0] x, input logic [63:0] y);
    pend_t p;
    int e;
    op = o; a = x; b = y; valid = 1'b1;
    e = cyc + 1;
    if (e >= free_from) begin
      p.e = model(o, x, y);
      if (o == 8'h0B || o == 8'h0C) begin
        p.due = e + 65;
        free_from = e + 66;
      end else begin
        p.due = e;
      end
      pq.push_back(p);
    end
    @(negedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pq.delete();
    last = '0;
    free_from = 0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 128'(0), 128'(1));
  endtask

  logic [63:0] vec_a [16];
  logic [63:0] vec_b [16];
  int at, e0;

  initial begin
    rst = 1'b1; valid = 1'b0; op = 8'h00; a = '0; b = '0;
    last = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1;
    rst = 1'b0;
    chk("reset_res", 128'(res), 128'(0));
    chk("reset_flags", 128'({done, zero, carry, overflow, lt, eq, gt}), 128'(0));

    drive(8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_wrap_res", 128'(res), 128'(0));
    chk("add_wrap_flags", 128'({done, zero, carry, overflow}), 128'(4'b1110));

    drive(8'h00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_ovf_res", 128'(res), 128'h8000_0000_0000_0000);
    chk("add_ovf_flags", 128'({carry, overflow, gt}), 128'(3'b011));

    drive(8'h09, 64'd5, 64'd7);
    chk("cmp_res", 128'(res), 128'hFFFF_FFFF_FFFF_FFFE);
    chk("cmp_flags", 128'({carry, lt, eq, zero}), 128'(4'b1100));

    drive(8'h08, 64'h8000_0000_0000_0000, 64'h43);
    chk("sar_res", 128'(res), 128'hF000_0000_0000_0000);

    // Back-to-back single-cycle ops across the opcode space, including undefined codes
    vec_a = '{64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0000,
              64'h7FFF_FFFF_FFFF_FFFF, 64'd42, 64'hDEAD_BEEF_0000_0001, 64'h5,
              64'hF0F0_F0F0_F0F0_F0F0, 64'd3, 64'hFFFF_FFFF_0000_0000, 64'h1,
              64'h8000_0000_0000_0001, 64'd100, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFE};
    vec_b = '{64'h0FED_CBA9_8765_4321, 64'h1, 64'h0, 64'h1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 64'h7F, 64'h40,
              64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFD, 64'h2, 64'h3F,
              64'h8000_0000_0000_0000, 64'd7, 64'h24, 64'h2};
    for (int o = 0; o < 18; o++) begin
      if (o == 8'h0B || o == 8'h0C) continue;
      for (int i = 0; i < 16; i += 3) drive(8'(o), vec_a[i], vec_b[i]);
    end
    drive(8'h0E, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    drive(8'h0E, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    drive(8'h0F, 64'h0, 64'd0);
    drive(8'h0F, 64'h8000_0000_0000_0000, 64'd0);
    drive(8'hFF, 64'd9, 64'd3);
    chk("undef_flags", 128'({done, zero, carry, overflow, lt, eq, gt}), 128'(7'b1000000));
    idle(2);

    // Divide with an ignored request in the middle
    e0 = cyc + 1;
    drive(8'h0B, 64'd100, 64'd7);
    idle(10);
    drive(8'h00, 64'd1, 64'd1);
    wait_done(at);
    chk("divu_latency", 128'(at - e0), 128'(65));
    chk("divu_res", 128'(res), 128'(14));
    idle(1);

    drive(8'h0C, 64'd100, 64'd7);
    wait_done(at);
    chk("remu_res", 128'(res), 128'(2));

    drive(8'h0B, 64'd12345, 64'd0);
    wait_done(at);
    chk("divz_res", 128'(res), 128'hFFFF_FFFF_FFFF_FFFF);
    chk("divz_ovf", 128'(overflow), 128'(1));

    drive(8'h0C, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
    wait_done(at);
    drive(8'h0B, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0003);
    wait_done(at);
    drive(8'h0C, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(at);
    drive(8'h01, 64'd3, 64'd3);
    idle(2);

    // Reset in the middle of a divide: outputs clear and no completion follows
    drive(8'h0B, 64'd1000, 64'd3);
    idle(20);
    do_reset();
    chk("rst_mid_res", 128'(res), 128'(0));
    chk("rst_mid_flags", 128'({done, zero, carry, overflow, lt, eq, gt}), 128'(0));
    idle(80);
    drive(8'h0D, 64'd0, 64'h55);
    chk("post_rst_mov", 128'(res), 128'h55);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
